xif_mac_coproc: RTL and testbench

- Minimal CORE-V-XIF coprocessor sitting directly downstream of the CPU's X-IF issue, commit and result channels.
- Accepts one custom-0 instruction at a time and holds it until commit.
- Executes either an iterative 32x32 multiply (low 32 bits) or a multiply-accumulate into an internal accumulator, then returns the result with a valid/ready handshake.
- Unsupported instructions are rejected in the issue cycle, so the CPU raises illegal-instruction.

---
 rtl/xif_mac_coproc_if.sv | 38 +++
 rtl/xif_mac_coproc.sv | 154 +++++++++++++++
 tb/tb_xif_mac_coproc.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_mac_coproc_if.sv
// X-IF issue/commit/result channel bundle between the CPU (master) and the MAC coprocessor (slave).
interface xif_mac_coproc_if #(
  parameter int ID_WIDTH = 4
);
  logic                issue_valid;
  logic                issue_ready;
  logic [31:0]         issue_instr;
  logic [ID_WIDTH-1:0] issue_id;
  logic [31:0]         issue_rs0;
  logic [31:0]         issue_rs1;
  logic [1:0]          issue_rs_valid;
  logic                issue_accept;
  logic                issue_writeback;
  logic                commit_valid;
  logic [ID_WIDTH-1:0] commit_id;
  logic                commit_kill;
  logic                result_valid;
  logic                result_ready;
  logic [ID_WIDTH-1:0] result_id;
  logic [31:0]         result_data;
  logic [4:0]          result_rd;
  logic                result_we;
  logic                busy;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
           commit_valid, commit_id, commit_kill, result_ready,
    input  issue_ready, issue_accept, issue_writeback,
           result_valid, result_id, result_data, result_rd, result_we, busy
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
           commit_valid, commit_id, commit_kill, result_ready,
    output issue_ready, issue_accept, issue_writeback,
           result_valid, result_id, result_data, result_rd, result_we, busy
  );
endinterface

// File: rtl/xif_mac_coproc.sv
// Single-slot X-IF coprocessor: MUL / MAC / CLRACC on custom-0, held until commit,
// with a 32-cycle shift-add multiplier and a valid/ready result port.
module xif_mac_coproc #(
  parameter int         ID_WIDTH = 4,
  parameter logic [6:0] OPCODE   = 7'b0001011
) (
  input  logic            clk_i,
  input  logic            rst_i,
  xif_mac_coproc_if.slave xif
);

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESULT} state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MAC    = 3'b001;
  localparam logic [2:0] F3_CLRACC = 3'b010;

  state_t state, state_next;

  logic [ID_WIDTH-1:0] id_q;
  logic [4:0]          rd_q;
  logic [2:0]          funct3_q;
  logic [31:0]         mcand_q;
  logic [31:0]         mplier_q;
  logic [31:0]         product_q;
  logic [31:0]         acc_q;
  logic [4:0]          count_q;

  logic [2:0]  dec_funct3;
  logic        supported;
  logic        issue_ready;
  logic        issue_fire;
  logic        commit_hit_idle;
  logic        commit_hit_wait;
  logic        exec_start;
  logic        result_valid;
  logic        result_fire;
  logic [31:0] acc_next;
  logic [31:0] result_value;

  assign dec_funct3 = xif.issue_instr[14:12];
  assign supported  = (xif.issue_instr[6:0] == OPCODE) &&
                      (xif.issue_instr[31:25] == 7'd0) &&
                      ((dec_funct3 == F3_MUL) || (dec_funct3 == F3_MAC) ||
                       (dec_funct3 == F3_CLRACC));

  // Every externally visible output is forced low while reset is asserted.
  assign issue_ready = !rst_i && (state == IDLE) && (xif.issue_rs_valid == 2'b11);
  assign issue_fire  = xif.issue_valid && issue_ready && supported;

  assign commit_hit_idle = issue_fire && xif.commit_valid && (xif.commit_id == xif.issue_id);
  assign commit_hit_wait = (state == WAIT_COMMIT) && xif.commit_valid && (xif.commit_id == id_q);

  assign result_valid = !rst_i && (state == RESULT);
  assign result_fire  = result_valid && xif.result_ready;
  assign acc_next     = acc_q + product_q;

  always_comb begin
    result_value = product_q;
    case (funct3_q)
      F3_MAC:    result_value = acc_next;
      F3_CLRACC: result_value = acc_q;
      default:   result_value = product_q;
    endcase
  end

  assign xif.issue_ready     = issue_ready;
  assign xif.issue_accept    = issue_fire;
  assign xif.issue_writeback = issue_fire;
  assign xif.result_valid    = result_valid;
  assign xif.result_we       = result_valid;
  assign xif.result_id       = result_valid ? id_q : '0;
  assign xif.result_rd       = result_valid ? rd_q : '0;
  assign xif.result_data     = result_valid ? result_value : '0;
  assign xif.busy            = !rst_i && (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A commit seen together with the issue handshake is handled exactly as in WAIT_COMMIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue_fire) begin
          if (commit_hit_idle) begin
            if (xif.commit_kill)              state_next = IDLE;
            else if (dec_funct3 == F3_CLRACC) state_next = RESULT;
            else                              state_next = EXEC;
          end else begin
            state_next = WAIT_COMMIT;
          end
        end
      end
      WAIT_COMMIT: begin
        if (commit_hit_wait) begin
          if (xif.commit_kill)            state_next = IDLE;
          else if (funct3_q == F3_CLRACC) state_next = RESULT;
          else                            state_next = EXEC;
        end
      end
      EXEC: begin
        if (count_q == 5'd31) state_next = RESULT;
      end
      RESULT: begin
        if (xif.result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign exec_start = (state != EXEC) && (state_next == EXEC);

  // Multiplier consumes one bit of rs2 per cycle, LSB first; the product wraps at 32 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q      <= '0;
      rd_q      <= '0;
      funct3_q  <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      acc_q     <= '0;
      count_q   <= '0;
    end else begin
      if (issue_fire) begin
        id_q     <= xif.issue_id;
        rd_q     <= xif.issue_instr[11:7];
        funct3_q <= dec_funct3;
        mcand_q  <= xif.issue_rs0;
        mplier_q <= xif.issue_rs1;
      end
      if (exec_start) begin
        count_q   <= '0;
        product_q <= '0;
      end else if (state == EXEC) begin
        if (mplier_q[0]) product_q <= product_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + 5'd1;
      end
      if (result_fire) begin
        if (funct3_q == F3_MAC)         acc_q <= acc_next;
        else if (funct3_q == F3_CLRACC) acc_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xif_mac_coproc.sv
// Randomized self-checking bench: an arithmetic accumulator model predicts each result,
// its latency after commit, and the issue-time accept/reject response.
module tb_xif_mac_coproc;

  localparam int         ID_WIDTH = 4;
  localparam logic [6:0] OPC      = 7'b0001011;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_model = '0;

  xif_mac_coproc_if #(.ID_WIDTH(ID_WIDTH)) xif ();

  xif_mac_coproc #(.ID_WIDTH(ID_WIDTH), .OPCODE(OPC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .xif   (xif)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] make_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] opc);
    logic [4:0] rs1f;
    logic [4:0] rs2f;
    rs1f = 5'($urandom_range(0, 31));
    rs2f = 5'($urandom_range(0, 31));
    return {f7, rs2f, rs1f, f3, rd, opc};
  endfunction

  function automatic bit model_supported(input logic [31:0] instr);
    return (instr[6:0] == OPC) && (instr[31:25] == 7'd0) && (instr[14:12] <= 3'd2);
  endfunction

  task automatic drive_quiet();
    xif.issue_valid    = 1'b0;
    xif.issue_instr    = '0;
    xif.issue_id       = '0;
    xif.issue_rs0      = '0;
    xif.issue_rs1      = '0;
    xif.issue_rs_valid = 2'b11;
    xif.commit_valid   = 1'b0;
    xif.commit_id      = '0;
    xif.commit_kill    = 1'b0;
    xif.result_ready   = 1'b0;
  endtask

  // One complete transaction from issue to result (or kill), checked against the model.
  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] id,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit same_cycle, input int junk_commits, input bit kill,
                               input int stall, input bit early_ready);
    bit          sup;
    bit          seen;
    logic [2:0]  f3;
    logic [63:0] full;
    logic [31:0] exp_data;
    int          exp_lat;
    int          lat;
    sup = model_supported(instr);
    f3  = instr[14:12];
    xif.issue_valid    = 1'b1;
    xif.issue_instr    = instr;
    xif.issue_id       = id;
    xif.issue_rs0      = a;
    xif.issue_rs1      = b;
    xif.issue_rs_valid = 2'b11;
    if (same_cycle) begin
      xif.commit_valid = 1'b1;
      xif.commit_id    = id;
      xif.commit_kill  = kill;
    end
    #1;
    checkOutput("issue_ready", 32'(xif.issue_ready), 32'd1);
    checkOutput("issue_accept", 32'(xif.issue_accept), 32'(sup));
    checkOutput("issue_writeback", 32'(xif.issue_writeback), 32'(sup));
    tick();
    xif.issue_valid  = 1'b0;
    xif.commit_valid = 1'b0;
    xif.commit_kill  = 1'b0;
    if (!sup) begin
      checkOutput("busy_after_reject", 32'(xif.busy), 32'd0);
      return;
    end
    if (!same_cycle) begin
      checkOutput("busy_wait_commit", 32'(xif.busy), 32'd1);
      for (int i = 0; i < junk_commits; i++) begin
        xif.commit_valid = 1'b1;
        xif.commit_id    = id + 4'(i + 2);
        xif.commit_kill  = 1'($urandom_range(0, 1));
        tick();
      end
      xif.commit_valid = 1'b1;
      xif.commit_id    = id;
      xif.commit_kill  = kill;
      tick();
      xif.commit_valid = 1'b0;
      xif.commit_kill  = 1'b0;
    end
    if (kill) begin
      checkOutput("busy_after_kill", 32'(xif.busy), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (xif.result_valid) seen = 1'b1;
        tick();
      end
      checkOutput("no_result_after_kill", 32'(seen), 32'd0);
      return;
    end
    full = 64'(a) * 64'(b);
    case (f3)
      3'b000:  exp_data = full[31:0];
      3'b001:  exp_data = acc_model + full[31:0];
      default: exp_data = acc_model;
    endcase
    exp_lat = (f3 == 3'b010) ? 1 : 33;
    // A competing issue while busy must be held off.
    xif.issue_valid  = 1'b1;
    xif.issue_instr  = make_instr(7'd0, 3'b000, 5'd1, OPC);
    xif.result_ready = early_ready;
    lat = 1;
    while (!xif.result_valid && lat < 100) begin
      tick();
      lat++;
    end
    checkOutput("result_latency", 32'(lat), 32'(exp_lat));
    checkOutput("blocked_issue_ready", 32'(xif.issue_ready), 32'd0);
    checkOutput("blocked_issue_accept", 32'(xif.issue_accept), 32'd0);
    checkOutput("result_data", xif.result_data, exp_data);
    checkOutput("result_id", 32'(xif.result_id), 32'(id));
    checkOutput("result_rd", 32'(xif.result_rd), 32'(instr[11:7]));
    checkOutput("result_we", 32'(xif.result_we), 32'd1);
    if (!early_ready) begin
      for (int i = 0; i < stall; i++) tick();
      if (stall > 0) begin
        checkOutput("stall_valid", 32'(xif.result_valid), 32'd1);
        checkOutput("stall_data", xif.result_data, exp_data);
        checkOutput("stall_id", 32'(xif.result_id), 32'(id));
        checkOutput("stall_rd", 32'(xif.result_rd), 32'(instr[11:7]));
      end
      xif.result_ready = 1'b1;
    end
    tick();
    xif.result_ready = 1'b0;
    xif.issue_valid  = 1'b0;
    if (f3 == 3'b001)      acc_model = exp_data;
    else if (f3 == 3'b010) acc_model = '0;
    checkOutput("valid_after_handshake", 32'(xif.result_valid), 32'd0);
    checkOutput("busy_after_handshake", 32'(xif.busy), 32'd0);
  endtask

  logic [31:0] mul_i, mac_i, clr_i;

  initial begin
    drive_quiet();
    rst_i = 1'b1;
    xif.issue_valid = 1'b1;
    xif.issue_instr = make_instr(7'd0, 3'b000, 5'd3, OPC);
    tick();
    tick();
    checkOutput("reset_issue_ready", 32'(xif.issue_ready), 32'd0);
    checkOutput("reset_issue_accept", 32'(xif.issue_accept), 32'd0);
    checkOutput("reset_busy", 32'(xif.busy), 32'd0);
    checkOutput("reset_result_valid", 32'(xif.result_valid), 32'd0);
    checkOutput("reset_result_data", xif.result_data, 32'd0);
    xif.issue_valid = 1'b0;
    rst_i = 1'b0;
    tick();
    checkOutput("idle_issue_ready", 32'(xif.issue_ready), 32'd1);

    mul_i = make_instr(7'd0, 3'b000, 5'd10, OPC);
    applyStimulus(mul_i, 4'd3, 32'd7, 32'd6, 1'b0, 0, 1'b0, 0, 1'b0);

    mac_i = make_instr(7'd0, 3'b001, 5'd11, OPC);
    clr_i = make_instr(7'd0, 3'b010, 5'd12, OPC);
    applyStimulus(mac_i, 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("mac_wrap_acc1", acc_model, 32'hFFFF_FFFE);
    applyStimulus(mac_i, 4'd2, 32'd3, 32'd1, 1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("mac_wrap_acc2", acc_model, 32'h0000_0001);
    applyStimulus(clr_i, 4'd4, 32'd0, 32'd0, 1'b0, 0, 1'b0, 0, 1'b0);
    applyStimulus(clr_i, 4'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0, 0, 1'b0);

    applyStimulus(make_instr(7'd0, 3'b011, 5'd1, OPC), 4'd6, 32'd1, 32'd1, 1'b0, 0, 1'b0, 0, 1'b0);
    applyStimulus(make_instr(7'd0, 3'b000, 5'd1, 7'b0110011), 4'd6, 32'd1, 32'd1, 1'b0, 0, 1'b0, 0, 1'b0);

    applyStimulus(mac_i, 4'd3, 32'd9, 32'd9, 1'b0, 1, 1'b1, 0, 1'b0);
    applyStimulus(clr_i, 4'd7, 32'd0, 32'd0, 1'b0, 0, 1'b0, 0, 1'b0);

    applyStimulus(mul_i, 4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 1'b0, 10, 1'b0);

    xif.issue_valid    = 1'b1;
    xif.issue_instr    = mul_i;
    xif.issue_rs_valid = 2'b01;
    #1;
    checkOutput("rs_invalid_ready", 32'(xif.issue_ready), 32'd0);
    checkOutput("rs_invalid_accept", 32'(xif.issue_accept), 32'd0);
    tick();
    drive_quiet();
    xif.commit_valid = 1'b1;
    xif.commit_id    = 4'd9;
    tick();
    xif.commit_valid = 1'b0;
    checkOutput("idle_commit_ignored", 32'(xif.busy), 32'd0);

    applyStimulus(mac_i, 4'd2, 32'd3, 32'd3, 1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("acc_before_reset", acc_model, 32'd9);
    xif.issue_valid = 1'b1;
    xif.issue_instr = mac_i;
    xif.issue_id    = 4'd4;
    xif.issue_rs0   = 32'd5;
    xif.issue_rs1   = 32'd5;
    xif.commit_valid = 1'b1;
    xif.commit_id    = 4'd4;
    tick();
    drive_quiet();
    for (int i = 0; i < 15; i++) tick();
    rst_i = 1'b1;
    #1;
    checkOutput("midexec_reset_busy", 32'(xif.busy), 32'd0);
    checkOutput("midexec_reset_ready", 32'(xif.issue_ready), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("post_reset_busy", 32'(xif.busy), 32'd0);
    checkOutput("post_reset_ready", 32'(xif.issue_ready), 32'd1);
    checkOutput("post_reset_valid", 32'(xif.result_valid), 32'd0);
    acc_model = '0;
    applyStimulus(clr_i, 4'd1, 32'd0, 32'd0, 1'b0, 0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int          r;
      logic [31:0] instr;
      logic [4:0]  rd;
      rd = 5'($urandom_range(0, 31));
      r  = $urandom_range(0, 9);
      if (r < 4)      instr = make_instr(7'd0, 3'b000, rd, OPC);
      else if (r < 7) instr = make_instr(7'd0, 3'b001, rd, OPC);
      else if (r < 9) instr = make_instr(7'd0, 3'b010, rd, OPC);
      else if ($urandom_range(0, 1) == 0)
        instr = make_instr(7'd0, 3'($urandom_range(3, 7)), rd, OPC);
      else
        instr = make_instr(7'($urandom_range(1, 127)), 3'b001, rd, OPC);
      applyStimulus(instr, 4'($urandom_range(0, 15)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom_range(0, 2),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0));
    end

    applyStimulus(clr_i, 4'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
